// File: rtl/usb_pkg.sv
// usb_pkg: shared PID codes, direction constants, packet-kind and FSM state
// enums for the USB host transaction engine.
package usb_pkg;

    // PID bytes, check nibble included
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    localparam logic DIR_OUT = 1'b0;
    localparam logic DIR_IN  = 1'b1;

    typedef enum logic [1:0] {
        KIND_TOKEN = 2'd0,
        KIND_DATA  = 2'd1,
        KIND_HS    = 2'd2
    } tx_kind_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TOKEN     = 3'd1,
        S_DATA_TX   = 3'd2,
        S_WAIT_HS   = 3'd3,
        S_WAIT_DATA = 3'd4,
        S_HS_TX     = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    function automatic logic is_data_pid(input logic [7:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_timer.sv
// usb_timer: response timeout counter. Held at zero while i_clr is high,
// counts while i_en is high and saturates at TIMEOUT_LEN; o_timeout is high
// whenever the count equals TIMEOUT_LEN.
module usb_timer #(
    parameter int TIMEOUT_LEN = 255
) (
    input  logic clk,
    input  logic rst_b,
    input  logic i_en,
    input  logic i_clr,
    output logic o_timeout
);
    localparam int            CW    = $clog2(TIMEOUT_LEN + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_LEN);

    logic [CW-1:0] r_cnt;

    // saturating cycle counter, cleared outside the wait states
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)                       r_cnt <= '0;
        else if (i_clr)                   r_cnt <= '0;
        else if (i_en && r_cnt != LIMIT)  r_cnt <= r_cnt + 1'b1;
    end

    assign o_timeout = (r_cnt == LIMIT);

endmodule

// File: rtl/usb_txn_engine.sv
// usb_txn_engine: host-side USB transaction engine. Runs one IN/OUT request
// at a time, emits token/DATA/handshake packets, retries on NAK, corruption
// or timeout, and reports status, retry count and IN payload.
// Optional feature macro: USB_DATA_TOGGLE_EN (per-endpoint DATA0/DATA1 toggle).
// Handshakes (req, tx): a transfer occurs on a cycle with valid & ready both
// high; once valid is raised it and its payload stay stable until transfer.
module usb_txn_engine
    import usb_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int NUM_EP      = 16,
    parameter int MAX_RETRY   = 8,
    parameter int TIMEOUT_LEN = 255
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dir,
    input  logic [6:0]        req_addr,
    input  logic [3:0]        req_endp,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    output logic              resp_ok,
    output logic [7:0]        resp_retries,
    output logic [DATA_W-1:0] resp_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [1:0]        tx_kind,
    output logic [7:0]        tx_pid,
    output logic [10:0]       tx_token,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_valid,
    input  logic [7:0]        rx_pid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_corrupt,
    input  logic              toggle_clr,
    output state_t            dbg_state
);
    localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

    state_t            r_state, w_next;
    logic              r_init;
    logic              r_dir;
    logic [6:0]        r_addr;
    logic [3:0]        r_endp;
    logic [DATA_W-1:0] r_data, r_rxd, r_resp_data;
    logic [7:0]        r_retries, r_resp_retries;
    logic              r_hs_ack, r_dup, r_resp_ok;

    logic w_waiting, w_timeout, w_accept;
    logic w_go_retry, w_finish, w_finish_ok, w_latch_rx;
    logic w_queue_hs, w_hs_ack, w_dup, w_flip, w_pid_match;
    logic [7:0] w_data_pid;

    assign w_waiting = (r_state == S_WAIT_HS) || (r_state == S_WAIT_DATA);

    usb_timer #(.TIMEOUT_LEN(TIMEOUT_LEN)) u_timer (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_en      (w_waiting),
        .i_clr     (!w_waiting),
        .o_timeout (w_timeout)
    );

`ifdef USB_DATA_TOGGLE_EN
    logic [NUM_EP-1:0] r_toggle;
    logic              r_out_tog;
    logic              w_tog;

    // toggle bit of the latched endpoint
    always_comb begin
        w_tog = 1'b0;
        for (int i = 0; i < NUM_EP; i++)
            if (r_endp == 4'(i)) w_tog = r_toggle[i];
    end

    // toggle storage; a clear beats a same-cycle flip
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_toggle  <= '0;
            r_out_tog <= 1'b0;
        end else begin
            if (toggle_clr)
                r_toggle <= '0;
            else if (w_flip)
                for (int i = 0; i < NUM_EP; i++)
                    if (r_endp == 4'(i)) r_toggle[i] <= ~r_toggle[i];
            // freeze the OUT DATA PID at token time so tx_pid stays stable
            if (r_state == S_TOKEN && tx_ready) r_out_tog <= w_tog;
        end
    end

    assign w_pid_match = ((rx_pid == PID_DATA1) == w_tog);
    assign w_data_pid  = r_out_tog ? PID_DATA1 : PID_DATA0;
`else
    logic w_unused_toggle;
    assign w_unused_toggle = toggle_clr ^ w_flip;
    assign w_pid_match     = 1'b1;
    assign w_data_pid      = PID_DATA0;
`endif

    assign req_ready    = (r_state == S_IDLE) && r_init;
    assign w_accept     = req_valid && req_ready;
    assign resp_valid   = (r_state == S_DONE);
    assign resp_ok      = r_resp_ok;
    assign resp_retries = r_resp_retries;
    assign resp_data    = r_resp_data;
    assign dbg_state    = r_state;

    // state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state, control strobes and tx packet outputs
    always_comb begin
        w_next      = r_state;
        w_go_retry  = 1'b0;
        w_finish    = 1'b0;
        w_finish_ok = 1'b0;
        w_latch_rx  = 1'b0;
        w_queue_hs  = 1'b0;
        w_hs_ack    = 1'b0;
        w_dup       = 1'b0;
        w_flip      = 1'b0;
        tx_valid    = 1'b0;
        tx_kind     = KIND_TOKEN;
        tx_pid      = 8'h00;
        tx_token    = 11'h000;
        tx_data     = '0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_TOKEN;
            S_TOKEN: begin
                tx_valid = 1'b1;
                tx_pid   = (r_dir == DIR_IN) ? PID_IN : PID_OUT;
                tx_token = {r_addr, r_endp};
                if (tx_ready) w_next = (r_dir == DIR_IN) ? S_WAIT_DATA : S_DATA_TX;
            end
            S_DATA_TX: begin
                tx_valid = 1'b1;
                tx_kind  = KIND_DATA;
                tx_pid   = w_data_pid;
                tx_data  = r_data;
                if (tx_ready) w_next = S_WAIT_HS;
            end
            S_WAIT_HS: begin
                if (rx_valid) begin
                    if (!rx_corrupt && rx_pid == PID_ACK) begin
                        w_finish    = 1'b1;
                        w_finish_ok = 1'b1;
                        w_flip      = 1'b1;
                    end else begin
                        w_go_retry = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_go_retry = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                if (rx_valid) begin
                    if (rx_corrupt) begin
                        w_queue_hs = 1'b1;
                    end else if (is_data_pid(rx_pid)) begin
                        w_queue_hs = 1'b1;
                        w_hs_ack   = 1'b1;
                        if (w_pid_match) begin
                            w_latch_rx = 1'b1;
                            w_flip     = 1'b1;
                        end else begin
                            w_dup = 1'b1;
                        end
                    end
                end else if (w_timeout) begin
                    w_go_retry = 1'b1;
                end
            end
            S_HS_TX: begin
                tx_valid = 1'b1;
                tx_kind  = KIND_HS;
                tx_pid   = r_hs_ack ? PID_ACK : PID_NAK;
                if (tx_ready) begin
                    if (r_hs_ack && !r_dup) begin
                        w_finish    = 1'b1;
                        w_finish_ok = 1'b1;
                    end else begin
                        w_go_retry = 1'b1;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_queue_hs) w_next = S_HS_TX;
        if (w_go_retry) begin
            if (r_retries < MAX_R) w_next = S_TOKEN;
            else                   w_finish = 1'b1;
        end
        if (w_finish) w_next = S_DONE;
    end

    // request latch, retry count, received payload and response registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_init         <= 1'b0;
            r_dir          <= 1'b0;
            r_addr         <= '0;
            r_endp         <= '0;
            r_data         <= '0;
            r_rxd          <= '0;
            r_retries      <= '0;
            r_hs_ack       <= 1'b0;
            r_dup          <= 1'b0;
            r_resp_ok      <= 1'b0;
            r_resp_retries <= '0;
            r_resp_data    <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_accept) begin
                r_dir     <= req_dir;
                r_addr    <= req_addr;
                r_endp    <= req_endp;
                r_data    <= req_data;
                r_rxd     <= '0;
                r_retries <= '0;
            end
            if (w_go_retry && r_retries < MAX_R) r_retries <= r_retries + 8'd1;
            if (w_latch_rx) r_rxd <= rx_data;
            if (w_queue_hs) begin
                r_hs_ack <= w_hs_ack;
                r_dup    <= w_dup;
            end
            if (w_finish) begin
                r_resp_ok      <= w_finish_ok;
                r_resp_retries <= r_retries;
                r_resp_data    <= w_finish_ok ? r_rxd : '0;
            end
        end
    end

endmodule

// File: tb/tb_usb_txn_engine.sv
// tb_usb_txn_engine: directed bench for usb_txn_engine. Instance u_dut uses
// MAX_RETRY=3, TIMEOUT_LEN=10; instance u_dut_b uses MAX_RETRY=2,
// TIMEOUT_LEN=10 for the no-response IN case.
module tb_usb_txn_engine;
    import usb_pkg::*;

    localparam int DW = 64;
`ifdef USB_DATA_TOGGLE_EN
    localparam bit TOGGLE_ON = 1'b1;
`else
    localparam bit TOGGLE_ON = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          req_valid, req_valid_b, req_dir;
    logic [6:0]    req_addr;
    logic [3:0]    req_endp;
    logic [DW-1:0] req_data;
    logic          tx_ready, rx_valid, rx_corrupt, toggle_clr;
    logic [7:0]    rx_pid;
    logic [DW-1:0] rx_data;

    logic          req_ready, resp_valid, resp_ok, tx_valid;
    logic [7:0]    resp_retries, tx_pid;
    logic [DW-1:0] resp_data, tx_data;
    logic [1:0]    tx_kind;
    logic [10:0]   tx_token;
    state_t        dbg_state;

    logic          b_req_ready, b_resp_valid, b_resp_ok, b_tx_valid;
    logic [7:0]    b_resp_retries, b_tx_pid;
    logic [DW-1:0] b_resp_data, b_tx_data;
    logic [1:0]    b_tx_kind;
    logic [10:0]   b_tx_token;
    state_t        b_dbg_state;

    usb_txn_engine #(.DATA_W(DW), .NUM_EP(16), .MAX_RETRY(3), .TIMEOUT_LEN(10)) u_dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_dir(req_dir), .req_addr(req_addr), .req_endp(req_endp), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ok(resp_ok), .resp_retries(resp_retries),
        .resp_data(resp_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_kind(tx_kind),
        .tx_pid(tx_pid), .tx_token(tx_token), .tx_data(tx_data), .rx_valid(rx_valid),
        .rx_pid(rx_pid), .rx_data(rx_data), .rx_corrupt(rx_corrupt),
        .toggle_clr(toggle_clr), .dbg_state(dbg_state)
    );

    usb_txn_engine #(.DATA_W(DW), .NUM_EP(16), .MAX_RETRY(2), .TIMEOUT_LEN(10)) u_dut_b (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid_b), .req_ready(b_req_ready),
        .req_dir(req_dir), .req_addr(req_addr), .req_endp(req_endp), .req_data(req_data),
        .resp_valid(b_resp_valid), .resp_ok(b_resp_ok), .resp_retries(b_resp_retries),
        .resp_data(b_resp_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready), .tx_kind(b_tx_kind),
        .tx_pid(b_tx_pid), .tx_token(b_tx_token), .tx_data(b_tx_data), .rx_valid(rx_valid),
        .rx_pid(rx_pid), .rx_data(rx_data), .rx_corrupt(rx_corrupt),
        .toggle_clr(toggle_clr), .dbg_state(b_dbg_state)
    );

    // clock and reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (start and end on a falling edge) ----------------
    task automatic issue_req(input logic dir, input logic [6:0] addr,
                             input logic [3:0] endp, input logic [DW-1:0] data);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        req_dir = dir; req_addr = addr; req_endp = endp; req_data = data;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_xfer(output logic [7:0] pid, output logic [1:0] kind,
                             output logic [DW-1:0] data);
        int n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        pid  = tx_valid ? tx_pid : 8'h00;
        kind = tx_kind;
        data = tx_data;
        @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] pid, input logic [DW-1:0] data, input logic bad);
        rx_valid = 1'b1; rx_pid = pid; rx_data = data; rx_corrupt = bad;
        @(negedge clk);
        rx_valid = 1'b0; rx_corrupt = 1'b0; rx_pid = 8'h00; rx_data = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (tx_pid !== 8'h00) begin n_bad++; $display("FAIL rst_tx_pid: got %h want 00", tx_pid); end
        n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", dbg_state, S_IDLE); end
        rst_b = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
        n_cmp++; if (b_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready_b: got %b want 1", b_req_ready); end
    endtask

    task automatic test_out_basic();
        logic [7:0] p; logic [1:0] k; logic [DW-1:0] d;
        issue_req(DIR_OUT, 7'h05, 4'h2, 64'hDEADBEEF_01234567);
        // token must already be on the bus the cycle after acceptance
        n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL out_latency: tx_valid got %b want 1", tx_valid); end
        n_cmp++; if (tx_token !== 11'h052) begin n_bad++; $display("FAIL out_token_field: got %h want 052", tx_token); end
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_OUT) begin n_bad++; $display("FAIL out_token_pid: got %h want E1", p); end
        n_cmp++; if (k !== 2'd0) begin n_bad++; $display("FAIL out_token_kind: got %0d want 0", k); end
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_DATA0) begin n_bad++; $display("FAIL out_data_pid: got %h want C3", p); end
        n_cmp++; if (k !== 2'd1) begin n_bad++; $display("FAIL out_data_kind: got %0d want 1", k); end
        n_cmp++; if (d !== 64'hDEADBEEF_01234567) begin n_bad++; $display("FAIL out_data_payload: got %h want DEADBEEF01234567", d); end
        send_rx(PID_ACK, '0, 1'b0);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL out_resp_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_ok !== 1'b1) begin n_bad++; $display("FAIL out_resp_ok: got %b want 1", resp_ok); end
        n_cmp++; if (resp_retries !== 8'd0) begin n_bad++; $display("FAIL out_resp_retries: got %0d want 0", resp_retries); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL out_resp_pulse: got %b want 0", resp_valid); end
        n_cmp++; if (resp_ok !== 1'b1) begin n_bad++; $display("FAIL out_resp_hold: got %b want 1", resp_ok); end
    endtask

    task automatic test_out_nak();
        logic [7:0] p; logic [1:0] k; logic [DW-1:0] d;
        issue_req(DIR_OUT, 7'h11, 4'h3, 64'h0123_4567_89AB_CDEF);
        for (int a = 0; a < 4; a++) begin
            wait_xfer(p, k, d);
            n_cmp++; if (p !== PID_OUT) begin n_bad++; $display("FAIL nak_token_%0d: got %h want E1", a, p); end
            wait_xfer(p, k, d);
            n_cmp++; if (p !== PID_DATA0) begin n_bad++; $display("FAIL nak_data_%0d: got %h want C3", a, p); end
            send_rx((a < 3) ? PID_NAK : PID_ACK, '0, 1'b0);
        end
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL nak_resp_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_ok !== 1'b1) begin n_bad++; $display("FAIL nak_resp_ok: got %b want 1", resp_ok); end
        n_cmp++; if (resp_retries !== 8'd3) begin n_bad++; $display("FAIL nak_resp_retries: got %0d want 3", resp_retries); end
        @(negedge clk);
    endtask

    task automatic test_in_timeout();
        int tok_cnt = 0;
        int last = -1;
        int cyc = 0;
        logic got_resp = 1'b0;
        for (int i = 0; i < 50 && !b_req_ready; i++) @(negedge clk);
        req_dir = DIR_IN; req_addr = 7'h33; req_endp = 4'h4; req_data = '0;
        req_valid_b = 1'b1;
        @(negedge clk);
        req_valid_b = 1'b0;
        while (!got_resp && cyc < 300) begin
            if (b_tx_valid) begin
                tok_cnt++;
                n_cmp++; if (b_tx_pid !== PID_IN) begin n_bad++; $display("FAIL to_token_pid: got %h want 69", b_tx_pid); end
                // token cycle + 11 wait cycles (count 0..10) before the retry token
                if (last >= 0) begin
                    n_cmp++; if (cyc - last !== 12) begin n_bad++; $display("FAIL to_token_gap: got %0d want 12", cyc - last); end
                end
                last = cyc;
            end
            if (b_resp_valid) begin
                got_resp = 1'b1;
                n_cmp++; if (b_resp_ok !== 1'b0) begin n_bad++; $display("FAIL to_resp_ok: got %b want 0", b_resp_ok); end
                n_cmp++; if (b_resp_retries !== 8'd2) begin n_bad++; $display("FAIL to_resp_retries: got %0d want 2", b_resp_retries); end
                n_cmp++; if (b_resp_data !== 64'h0) begin n_bad++; $display("FAIL to_resp_data: got %h want 0", b_resp_data); end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        n_cmp++; if (got_resp !== 1'b1) begin n_bad++; $display("FAIL to_resp_seen: got %b want 1", got_resp); end
        n_cmp++; if (tok_cnt !== 3) begin n_bad++; $display("FAIL to_token_count: got %0d want 3", tok_cnt); end
        @(negedge clk);
    endtask

    task automatic test_in_corrupt();
        logic [7:0] p; logic [1:0] k; logic [DW-1:0] d;
        issue_req(DIR_IN, 7'h22, 4'h5, '0);
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_IN) begin n_bad++; $display("FAIL cor_token1: got %h want 69", p); end
        send_rx(PID_DATA0, 64'h1234_0000_0000_4321, 1'b1);
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_NAK) begin n_bad++; $display("FAIL cor_nak: got %h want 5A", p); end
        n_cmp++; if (k !== 2'd2) begin n_bad++; $display("FAIL cor_nak_kind: got %0d want 2", k); end
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_IN) begin n_bad++; $display("FAIL cor_token2: got %h want 69", p); end
        send_rx(PID_DATA0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_ACK) begin n_bad++; $display("FAIL cor_ack: got %h want D2", p); end
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL cor_resp_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_ok !== 1'b1) begin n_bad++; $display("FAIL cor_resp_ok: got %b want 1", resp_ok); end
        n_cmp++; if (resp_retries !== 8'd1) begin n_bad++; $display("FAIL cor_resp_retries: got %0d want 1", resp_retries); end
        n_cmp++; if (resp_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_bad++; $display("FAIL cor_resp_data: got %h want A5A5A5A5A5A5A5A5", resp_data); end
        @(negedge clk);
    endtask

    task automatic test_toggle();
        logic [7:0] p; logic [1:0] k; logic [DW-1:0] d;
        logic [7:0] exp_pid;
        for (int t = 0; t < 2; t++) begin
            issue_req(DIR_OUT, 7'h0A, 4'h1, 64'h1111_0000 + 64'(t));
            wait_xfer(p, k, d);
            wait_xfer(p, k, d);
            exp_pid = (TOGGLE_ON && t == 1) ? PID_DATA1 : PID_DATA0;
            n_cmp++; if (p !== exp_pid) begin n_bad++; $display("FAIL tog_out_pid_%0d: got %h want %h", t, p, exp_pid); end
            send_rx(PID_ACK, '0, 1'b0);
            n_cmp++; if (resp_ok !== 1'b1) begin n_bad++; $display("FAIL tog_out_ok_%0d: got %b want 1", t, resp_ok); end
            @(negedge clk);
        end
        issue_req(DIR_IN, 7'h0A, 4'h1, '0);
        wait_xfer(p, k, d);
        send_rx(PID_DATA1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_ACK) begin n_bad++; $display("FAIL tog_in_ack1: got %h want D2", p); end
`ifdef USB_DATA_TOGGLE_EN
        // duplicate DATA1 was discarded; the IN is retried
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_IN) begin n_bad++; $display("FAIL tog_in_retry_token: got %h want 69", p); end
        send_rx(PID_DATA0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_ACK) begin n_bad++; $display("FAIL tog_in_ack2: got %h want D2", p); end
        n_cmp++; if (resp_retries !== 8'd1) begin n_bad++; $display("FAIL tog_in_retries: got %0d want 1", resp_retries); end
        n_cmp++; if (resp_data !== 64'h0F0F_0F0F_0F0F_0F0F) begin n_bad++; $display("FAIL tog_in_data: got %h want 0F0F0F0F0F0F0F0F", resp_data); end
`else
        n_cmp++; if (resp_retries !== 8'd0) begin n_bad++; $display("FAIL tog_in_retries: got %0d want 0", resp_retries); end
        n_cmp++; if (resp_data !== 64'hBAD0_BAD0_BAD0_BAD0) begin n_bad++; $display("FAIL tog_in_data: got %h want BAD0BAD0BAD0BAD0", resp_data); end
`endif
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL tog_in_resp_valid: got %b want 1", resp_valid); end
        @(negedge clk);
        toggle_clr = 1'b1;
        @(negedge clk);
        toggle_clr = 1'b0;
        issue_req(DIR_OUT, 7'h0A, 4'h1, 64'h2222);
        wait_xfer(p, k, d);
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_DATA0) begin n_bad++; $display("FAIL tog_clr_pid: got %h want C3", p); end
        send_rx(PID_ACK, '0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_idle_rx_and_stall();
        logic [7:0] p; logic [1:0] k; logic [DW-1:0] d;
        // an ACK while idle must be ignored
        send_rx(PID_ACK, '0, 1'b0);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL idle_rx_resp: got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_rx_ready: got %b want 1", req_ready); end
        tx_ready = 1'b0;
        issue_req(DIR_OUT, 7'h44, 4'h6, 64'h5555_6666_7777_8888);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_pid !== PID_OUT || tx_token !== 11'h446) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got v=%b pid=%h tok=%h want v=1 pid=E1 tok=446", i, tx_valid, tx_pid, tx_token);
            end
            @(negedge clk);
        end
        tx_ready = 1'b1;
        wait_xfer(p, k, d);
        n_cmp++; if (p !== PID_OUT) begin n_bad++; $display("FAIL stall_token: got %h want E1", p); end
        wait_xfer(p, k, d);
        n_cmp++; if (d !== 64'h5555_6666_7777_8888) begin n_bad++; $display("FAIL stall_data: got %h want 5555666677778888", d); end
        send_rx(PID_ACK, '0, 1'b0);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL stall_resp: got %b want 1", resp_valid); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] p; logic [1:0] k; logic [DW-1:0] d;
        logic seen = 1'b0;
        issue_req(DIR_OUT, 7'h55, 4'h7, 64'h9999);
        wait_xfer(p, k, d);
        wait_xfer(p, k, d);
        n_cmp++; if (dbg_state !== S_WAIT_HS) begin n_bad++; $display("FAIL mid_in_wait_hs: got %0d want %0d", dbg_state, S_WAIT_HS); end
        rst_b = 1'b0;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (resp_ok !== 1'b0) begin n_bad++; $display("FAIL mid_resp_ok: got %b want 0", resp_ok); end
        n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL mid_state: got %0d want %0d", dbg_state, S_IDLE); end
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        rx_valid = 1'b1; rx_pid = PID_ACK;
        @(negedge clk);
        rx_valid = 1'b0; rx_pid = 8'h00;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_after: got %b want 1", req_ready); end
        for (int i = 0; i < 6; i++) begin
            if (resp_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_resp: got %b want 0", seen); end
    endtask

    initial begin
        req_valid = 1'b0; req_valid_b = 1'b0; req_dir = 1'b0; req_addr = '0; req_endp = '0;
        req_data = '0; tx_ready = 1'b1; rx_valid = 1'b0; rx_corrupt = 1'b0; rx_pid = 8'h00;
        rx_data = '0; toggle_clr = 1'b0;
        test_reset();
        test_out_basic();
        test_out_nak();
        test_in_timeout();
        test_in_corrupt();
        test_toggle();
        test_idle_rx_and_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
